// File: rtl/i2c_master_cmdqueue_rx_fifo.sv
// Rx side of the I2C master command queue: packs received bytes into 32-bit words and
// returns them over Wishbone reads. Define I2C_RX_FIFO_PACK_EN to enable byte packing.
module i2c_master_cmdqueue_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RSTn_i,
  input  logic                  WBs_CYC_i,
  input  logic                  WBs_STB_i,
  input  logic                  WBs_WE_i,
  output logic [31:0]           WBs_DAT_o,
  output logic                  WBs_ACK_o,
  input  logic                  Rx_FIFO_Flush_i,
  input  logic [7:0]            Rx_Byte_DAT_i,
  input  logic                  Rx_Byte_Push_i,
  input  logic                  Rx_Xfer_Done_i,
  output logic [3:0]            Rx_FIFO_BYTE_STB_o,
  output logic                  Rx_FIFO_Empty_o,
  output logic                  Rx_FIFO_Full_o,
  output logic [DEPTH_LOG2:0]   Rx_FIFO_Level_o,
  output logic                  Rx_Byte_Drop_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic        commit_req;
  logic [31:0] commit_data;
  logic [3:0]  commit_mask;

`ifdef I2C_RX_FIFO_PACK_EN
  logic [1:0]  byte_cnt_reg;
  logic [23:0] stage_reg;
  logic [2:0]  fill_cnt;
  logic [31:0] merged;

  // Unused upper staging bytes are always zero, so a partial commit needs no masking.
  always_comb begin
    merged = {8'h00, stage_reg};
    if (Rx_Byte_Push_i)
      merged = merged | ({24'h0, Rx_Byte_DAT_i} << {byte_cnt_reg, 3'b000});
    fill_cnt    = {1'b0, byte_cnt_reg} + {2'b00, Rx_Byte_Push_i};
    commit_req  = (fill_cnt == 3'd4) || (Rx_Xfer_Done_i && (fill_cnt != 3'd0));
    commit_data = merged;
    case (fill_cnt)
      3'd1:    commit_mask = 4'h1;
      3'd2:    commit_mask = 4'h3;
      3'd3:    commit_mask = 4'h7;
      default: commit_mask = 4'hF;
    endcase
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      byte_cnt_reg <= 2'd0;
      stage_reg    <= 24'h0;
    end else if (Rx_FIFO_Flush_i || commit_req) begin
      byte_cnt_reg <= 2'd0;
      stage_reg    <= 24'h0;
    end else if (Rx_Byte_Push_i) begin
      byte_cnt_reg <= fill_cnt[1:0];
      stage_reg    <= merged[23:0];
    end
  end
`else
  logic unused_xfer_done;
  assign unused_xfer_done = Rx_Xfer_Done_i;

  always_comb begin
    commit_req  = Rx_Byte_Push_i;
    commit_data = {24'h0, Rx_Byte_DAT_i};
    commit_mask = 4'h1;
  end
`endif

  logic [35:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic                  empty_reg, full_reg, drop_reg, ack_reg;
  logic [31:0]           dat_reg, dat_next;
  logic [35:0]           head;
  logic                  ack_next, rd_req, pop, wr_en;

  assign head = mem[rd_ptr_reg];

  always_comb begin
    ack_next = WBs_CYC_i & WBs_STB_i & ~ack_reg;
    rd_req   = ack_next & ~WBs_WE_i;
    pop      = rd_req & ~empty_reg & ~Rx_FIFO_Flush_i;
    // A pop in the same cycle frees the slot the commit needs.
    wr_en    = commit_req & (~full_reg | pop) & ~Rx_FIFO_Flush_i;
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
    dat_next = dat_reg;
    if (rd_req)
      dat_next = (Rx_FIFO_Flush_i || empty_reg) ? 32'h0 : head[31:0];
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (wr_en)
      mem[wr_ptr_reg] <= {commit_mask, commit_data};
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      drop_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      dat_reg    <= 32'h0;
    end else begin
      ack_reg <= ack_next;
      dat_reg <= dat_next;
      if (Rx_FIFO_Flush_i) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        level_reg  <= '0;
        empty_reg  <= 1'b1;
        full_reg   <= 1'b0;
        drop_reg   <= 1'b0;
      end else begin
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (wr_en)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (commit_req && !wr_en)
          drop_reg <= 1'b1;
        level_reg <= level_next;
        empty_reg <= (level_next == '0);
        full_reg  <= (level_next == LEVEL_FULL);
      end
    end
  end

  assign WBs_ACK_o          = ack_reg;
  assign WBs_DAT_o          = dat_reg;
  assign Rx_FIFO_Empty_o    = empty_reg;
  assign Rx_FIFO_Full_o     = full_reg;
  assign Rx_FIFO_Level_o    = level_reg;
  assign Rx_Byte_Drop_o     = drop_reg;
  assign Rx_FIFO_BYTE_STB_o = empty_reg ? 4'h0 : head[35:32];

endmodule

// File: tb/tb_i2c_master_cmdqueue_rx_fifo.sv
// Scoreboard bench for i2c_master_cmdqueue_rx_fifo; follows I2C_RX_FIFO_PACK_EN like the RTL.
module tb_i2c_master_cmdqueue_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        flush;
  logic [7:0]  byte_dat;
  logic        byte_push, xfer_done;
  logic [3:0]  byte_stb_o;
  logic        empty_o, full_o, drop_o;
  logic [4:0]  level_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q[$];
  int          exp_cnt   = 0;
  logic [31:0] exp_stage = 32'h0;
  logic        exp_drop  = 1'b0;

  always #5 clk = ~clk;

  i2c_master_cmdqueue_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .WBs_CLK_i          (clk),
    .WBs_RSTn_i         (rst_n),
    .WBs_CYC_i          (cyc),
    .WBs_STB_i          (stb),
    .WBs_WE_i           (we),
    .WBs_DAT_o          (dat_o),
    .WBs_ACK_o          (ack_o),
    .Rx_FIFO_Flush_i    (flush),
    .Rx_Byte_DAT_i      (byte_dat),
    .Rx_Byte_Push_i     (byte_push),
    .Rx_Xfer_Done_i     (xfer_done),
    .Rx_FIFO_BYTE_STB_o (byte_stb_o),
    .Rx_FIFO_Empty_o    (empty_o),
    .Rx_FIFO_Full_o     (full_o),
    .Rx_FIFO_Level_o    (level_o),
    .Rx_Byte_Drop_o     (drop_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_commit(input logic [3:0] m, input logic [31:0] d);
    if (exp_q.size() < 16) exp_q.push_back({m, d});
    else exp_drop = 1'b1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
`ifdef I2C_RX_FIFO_PACK_EN
    exp_stage = exp_stage | (32'(b) << (8 * exp_cnt));
    exp_cnt++;
    if (exp_cnt == 4) begin
      model_commit(4'hF, exp_stage);
      exp_cnt   = 0;
      exp_stage = 32'h0;
    end
`else
    model_commit(4'h1, {24'h0, b});
`endif
  endfunction

  function automatic void model_done();
`ifdef I2C_RX_FIFO_PACK_EN
    if (exp_cnt > 0) begin
      model_commit((exp_cnt == 1) ? 4'h1 : (exp_cnt == 2) ? 4'h3 : 4'h7, exp_stage);
      exp_cnt   = 0;
      exp_stage = 32'h0;
    end
`endif
  endfunction

  task automatic check_status(input string tag);
    check_val({tag, "_level"}, 64'(level_o), 64'(exp_q.size()));
    check_val({tag, "_empty"}, 64'(empty_o), 64'(exp_q.size() == 0));
    check_val({tag, "_full"},  64'(full_o),  64'(exp_q.size() == 16));
    check_val({tag, "_drop"},  64'(drop_o),  64'(exp_drop));
  endtask

  task automatic push_byte(input logic [7:0] b);
    byte_dat  = b;
    byte_push = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    byte_push = 1'b0;
  endtask

  task automatic pulse_done();
    xfer_done = 1'b1;
    model_done();
    @(posedge clk); #1;
    xfer_done = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
`ifdef I2C_RX_FIFO_PACK_EN
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
`else
    push_byte(w[7:0]);
`endif
  endtask

  task automatic wb_read(input string tag);
    logic [35:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : 36'h0;
    check_val({tag, "_stb"}, 64'(byte_stb_o), 64'(e[35:32]));
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    cyc = 1'b0; stb = 1'b0;
    check_val({tag, "_ack"}, 64'(ack_o), 64'd1);
    check_val({tag, "_dat"}, 64'(dat_o), 64'(e[31:0]));
    check_val({tag, "_lvl"}, 64'(level_o), 64'(exp_q.size()));
    @(posedge clk); #1;
    check_val({tag, "_ackdrop"}, 64'(ack_o), 64'd0);
  endtask

  // Read and push the word-completing byte on the same edge.
  task automatic read_and_push(input string tag, input logic [7:0] b);
    logic [35:0] e;
    e = exp_q.pop_front();
    model_byte(b);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    byte_dat = b; byte_push = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; byte_push = 1'b0;
    check_val({tag, "_ack"}, 64'(ack_o), 64'd1);
    check_val({tag, "_dat"}, 64'(dat_o), 64'(e[31:0]));
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    exp_cnt   = 0;
    exp_stage = 32'h0;
    exp_drop  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ack"},   64'(ack_o),      64'd0);
    check_val({tag, "_dat"},   64'(dat_o),      64'd0);
    check_val({tag, "_empty"}, 64'(empty_o),    64'd1);
    check_val({tag, "_full"},  64'(full_o),     64'd0);
    check_val({tag, "_level"}, 64'(level_o),    64'd0);
    check_val({tag, "_stb"},   64'(byte_stb_o), 64'd0);
    check_val({tag, "_drop"},  64'(drop_o),     64'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) wb_read(tag);
    check_status({tag, "_drained"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    flush = 1'b0; byte_dat = 8'h0; byte_push = 1'b0; xfer_done = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic packing: 5 bytes then done.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    push_byte(8'h44); push_byte(8'h55);
    pulse_done();
    check_status("pack");
    drain("pack");

    // Read while empty.
    wb_read("empty_rd");
    check_status("empty_rd");

    // Fill, overflow by one, drain in order.
    for (int i = 0; i < 17; i++) push_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    check_status("ovf");
    drain("ovf");

    // Second fill exercises pointer wrap.
    for (int i = 0; i < 16; i++) push_word({8'(i), 8'hC3, 8'h5A, 8'(8'h80 + i)});
    check_status("fill2");
    drain("fill2");

    do_flush();
    check_status("flush_clr");

    // Full with simultaneous commit and read.
    for (int i = 0; i < 16; i++) push_word({8'hE0, 8'(i), 8'h0F, 8'(8'h40 + i)});
    check_status("full");
`ifdef I2C_RX_FIFO_PACK_EN
    push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
`endif
    read_and_push("full_rw", 8'hD4);
    check_status("full_rw");
    drain("full_rw");

    // Flush with words queued and bytes staged.
    for (int i = 0; i < 3; i++) push_word(32'h9000_0000 + 32'(i));
    push_byte(8'hAA); push_byte(8'hBB);
    for (int i = 0; i < 17; i++) push_word(32'h7700_0000 + 32'(i));
    check_val("pre_flush_drop", 64'(drop_o), 64'd1);
    do_flush();
    check_status("flush");
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    check_status("post_flush");
    drain("post_flush");

    // Asynchronous reset mid-word.
    push_byte(8'h61); push_byte(8'h62);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_q.delete(); exp_cnt = 0; exp_stage = 32'h0; exp_drop = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push_byte(8'hA5);
    pulse_done();
    check_status("after_rst");
    drain("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
